// File: rtl/sad_mode_accum_if.sv
// Handshake/bus bundle for sad_mode_accum: residual input stream, block control and result port.
interface sad_mode_accum_if #(
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned LANES     = 16,
    parameter int unsigned SAMPLE_W  = 9,
    parameter int unsigned SAD_W     = 17
);
    localparam int unsigned MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int unsigned DATA_W = NUM_MODES * LANES * SAMPLE_W;

    logic                          start;
    logic [NUM_MODES-1:0]          mode_mask;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             res_data;
    logic                          busy;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_MODES*SAD_W-1:0]    sads;
    logic [MODE_W-1:0]             best_mode;
    logic [SAD_W-1:0]              best_sad;

    modport master (
        output start, mode_mask, in_valid, res_data, out_ready,
        input  in_ready, busy, out_valid, sads, best_mode, best_sad
    );

    modport slave (
        input  start, mode_mask, in_valid, res_data, out_ready,
        output in_ready, busy, out_valid, sads, best_mode, best_sad
    );
endinterface

// File: rtl/sad_mode_accum.sv
// Streaming per-mode SAD accumulator with sequential minimum-SAD mode selection.
module sad_mode_accum #(
    parameter int unsigned NUM_MODES   = 4,
    parameter int unsigned LANES       = 16,
    parameter int unsigned BLK_SAMPLES = 256,
    parameter int unsigned SAMPLE_W    = 9,
    parameter int unsigned SAD_W       = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    sad_mode_accum_if.slave  bus
);
    localparam int unsigned MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int unsigned BEATS     = BLK_SAMPLES / LANES;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BSUM_W    = SAMPLE_W + $clog2(LANES);
    localparam int unsigned ACC_EXT_W = ((SAD_W > BSUM_W) ? SAD_W : BSUM_W) + 1;
    localparam int unsigned TREE_N    = 2 * LANES - 1;
    localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_CMP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_MODES-1:0] mask_q, mask_d;
    logic [MODE_W-1:0]   idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, busy_q;
    logic                accept_c, start_c;

    logic                s1_valid_q;
    logic [BSUM_W-1:0]   bsum_q     [NUM_MODES];
    logic [BSUM_W-1:0]   beat_sum_c [NUM_MODES];
    logic [BSUM_W-1:0]   tree       [NUM_MODES][TREE_N];
    logic [SAMPLE_W-1:0] smp, mag;
    logic [SAD_W-1:0]    acc_q      [NUM_MODES];
    logic [SAD_W-1:0]    acc_sat_c  [NUM_MODES];
    logic [ACC_EXT_W-1:0] acc_ext;
    logic [SAD_W-1:0]    sads_q     [NUM_MODES];
    logic                found_q;
    logic [MODE_W-1:0]   best_mode_q;
    logic [SAD_W-1:0]    best_sad_q;

    assign accept_c = (state_q == S_ACCUM) && bus.in_valid;
    assign start_c  = (state_q == S_IDLE) && bus.start;

    // Next-state and control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    mask_d  = bus.mode_mask;
                end
            end
            S_ACCUM: begin
                if (accept_c) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(BEATS - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_CMP;
                idx_d   = '0;
            end
            S_CMP: begin
                idx_d = MODE_W'(idx_q + 1'b1);
                if (idx_q == MODE_W'(NUM_MODES - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                // out_valid trails DONE entry by one cycle so CMP results are registered first
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= (state_d == S_ACCUM);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Stage 1: per-lane magnitude into a heap-ordered adder tree (leaves at LANES-1..)
    always_comb begin
        smp = '0;
        mag = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            for (int n = 0; n < TREE_N; n++) tree[m][n] = '0;
            for (int l = 0; l < LANES; l++) begin
                smp = bus.res_data[(m*LANES+l)*SAMPLE_W +: SAMPLE_W];
                mag = smp[SAMPLE_W-1] ? (~smp + 1'b1) : smp;
                tree[m][LANES-1+l] = BSUM_W'(mag);
            end
            for (int n = int'(LANES) - 2; n >= 0; n--) begin
                tree[m][n] = tree[m][2*n+1] + tree[m][2*n+2];
            end
            beat_sum_c[m] = tree[m][0];
        end
    end

    // Stage 2: saturating accumulate; saturation is sticky since the sum never decreases
    always_comb begin
        acc_ext = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            acc_ext      = ACC_EXT_W'(acc_q[m]) + ACC_EXT_W'(bsum_q[m]);
            acc_sat_c[m] = (acc_ext > ACC_EXT_W'(SAD_MAX)) ? SAD_MAX : SAD_W'(acc_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            found_q     <= 1'b0;
            best_mode_q <= '0;
            best_sad_q  <= SAD_MAX;
            for (int m = 0; m < NUM_MODES; m++) begin
                bsum_q[m] <= '0;
                acc_q[m]  <= '0;
                sads_q[m] <= '0;
            end
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                for (int m = 0; m < NUM_MODES; m++) bsum_q[m] <= beat_sum_c[m];
            end
            if (start_c) begin
                for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
            end else if (s1_valid_q) begin
                for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= acc_sat_c[m];
            end
            if (state_q == S_DRAIN) begin
                found_q     <= 1'b0;
                best_mode_q <= '0;
                best_sad_q  <= SAD_MAX;
            end else if (state_q == S_CMP) begin
                sads_q[idx_q] <= acc_q[idx_q];
                // strict less-than keeps ties on the lowest index
                if (mask_q[idx_q] && (!found_q || (acc_q[idx_q] < best_sad_q))) begin
                    found_q     <= 1'b1;
                    best_mode_q <= idx_q;
                    best_sad_q  <= acc_q[idx_q];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_MODES; g++) begin : g_sads
        assign bus.sads[g*SAD_W +: SAD_W] = sads_q[g];
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.best_mode = best_mode_q;
    assign bus.best_sad  = best_sad_q;
endmodule

// File: tb/tb_sad_mode_accum.sv
// Scoreboard bench for sad_mode_accum: a 17-bit and a 16-bit SAD instance share one stimulus stream.
module tb_sad_mode_accum;
    localparam int unsigned NM    = 4;
    localparam int unsigned L     = 16;
    localparam int unsigned BLK   = 256;
    localparam int unsigned SW    = 9;
    localparam int unsigned BEATS = BLK / L;
    localparam int unsigned DW    = NM * L * SW;

    typedef struct {
        longint sad [NM];
        longint bm;
        longint bs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sad_mode_accum_if #(.NUM_MODES(NM), .LANES(L), .SAMPLE_W(SW), .SAD_W(17)) a_if ();
    sad_mode_accum_if #(.NUM_MODES(NM), .LANES(L), .SAMPLE_W(SW), .SAD_W(16)) b_if ();

    assign b_if.start     = a_if.start;
    assign b_if.mode_mask = a_if.mode_mask;
    assign b_if.in_valid  = a_if.in_valid;
    assign b_if.res_data  = a_if.res_data;
    assign b_if.out_ready = a_if.out_ready;

    sad_mode_accum #(.NUM_MODES(NM), .LANES(L), .BLK_SAMPLES(BLK), .SAMPLE_W(SW), .SAD_W(17))
        u_dut17 (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    sad_mode_accum #(.NUM_MODES(NM), .LANES(L), .BLK_SAMPLES(BLK), .SAMPLE_W(SW), .SAD_W(16))
        u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int     n_cmp = 0;
    int     n_bad = 0;
    exp_t   q17 [$];
    exp_t   q16 [$];
    longint tot [NM];
    int     cur_vals [NM];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: clip each total to the width, then pick the smallest enabled SAD, lowest index first.
    function automatic exp_t model(input longint t [NM], input logic [NM-1:0] mask, input longint maxv);
        exp_t   e;
        longint mn = -1;
        for (int m = 0; m < NM; m++) e.sad[m] = (t[m] > maxv) ? maxv : t[m];
        for (int m = 0; m < NM; m++)
            if (mask[m] && (mn < 0 || e.sad[m] < mn)) mn = e.sad[m];
        e.bm = 0;
        e.bs = maxv;
        if (mn >= 0) begin
            e.bs = mn;
            for (int m = NM - 1; m >= 0; m--)
                if (mask[m] && e.sad[m] == mn) e.bm = m;
        end
        return e;
    endfunction

    // Monitor: pops an expectation whenever a result is handed over
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            if (q17.size() == 0) check("sb17_unexpected_output", 1, 0);
            else begin
                e = q17.pop_front();
                for (int m = 0; m < NM; m++)
                    check($sformatf("sad17[%0d]", m), longint'(a_if.sads[m*17 +: 17]), e.sad[m]);
                check("best_mode17", longint'(a_if.best_mode), e.bm);
                check("best_sad17", longint'(a_if.best_sad), e.bs);
            end
        end
        if (rst_n && b_if.out_valid && b_if.out_ready) begin
            if (q16.size() == 0) check("sb16_unexpected_output", 1, 0);
            else begin
                e = q16.pop_front();
                for (int m = 0; m < NM; m++)
                    check($sformatf("sad16[%0d]", m), longint'(b_if.sads[m*16 +: 16]), e.sad[m]);
                check("best_mode16", longint'(b_if.best_mode), e.bm);
                check("best_sad16", longint'(b_if.best_sad), e.bs);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] rd;
        for (int i = 0; i < NM * L; i++) rd[i*SW +: SW] = SW'($urandom);
        return rd;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (a_if.busy && k < 200) begin
            tick();
            k++;
        end
        if (a_if.busy) check("idle_timeout", longint'(a_if.busy), 0);
    endtask

    task automatic start_block(input logic [NM-1:0] mask);
        wait_idle();
        for (int m = 0; m < NM; m++) tot[m] = 0;
        a_if.mode_mask = mask;
        a_if.start     = 1'b1;
        tick();
        a_if.start     = 1'b0;
        a_if.mode_mask = ~mask;
    endtask

    task automatic drive_beats(input int kind, input int gap, input bit noise, input int nbeats);
        logic [DW-1:0] rd;
        int v, k;
        for (int b = 0; b < nbeats; b++) begin
            while ($urandom_range(0, 99) < gap) begin
                a_if.in_valid = 1'b0;
                a_if.res_data = rand_data();
                tick();
            end
            for (int m = 0; m < NM; m++) begin
                for (int l = 0; l < L; l++) begin
                    v = (kind == 0) ? cur_vals[m] : int'($urandom_range(0, 511)) - 256;
                    rd[(m*L+l)*SW +: SW] = SW'(v);
                    tot[m] += (v < 0) ? -v : v;
                end
            end
            a_if.res_data = rd;
            a_if.in_valid = 1'b1;
            if (noise) begin
                a_if.start     = 1'($urandom_range(0, 1));
                a_if.mode_mask = NM'($urandom);
            end
            k = 0;
            while (!a_if.in_ready && k < 50) begin
                tick();
                k++;
            end
            if (!a_if.in_ready) check("in_ready_timeout", longint'(a_if.in_ready), 1);
            tick();
        end
        a_if.in_valid = 1'b0;
        a_if.start    = 1'b0;
    endtask

    task automatic check_latency();
        int k = 0;
        do begin
            tick();
            k++;
        end while (!a_if.out_valid && k < 40);
        check("latency_cycles", k, NM + 2);
    endtask

    task automatic hold_check();
        logic [NM*17-1:0] s;
        logic [1:0]       bm;
        logic [16:0]      bs;
        bit               stable = 1'b1;
        int               k = 0;
        while (!a_if.out_valid && k < 60) begin
            tick();
            k++;
        end
        check("hold_valid_seen", longint'(a_if.out_valid), 1);
        s  = a_if.sads;
        bm = a_if.best_mode;
        bs = a_if.best_sad;
        a_if.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!a_if.out_valid || a_if.sads !== s || a_if.best_mode !== bm || a_if.best_sad !== bs)
                stable = 1'b0;
        end
        check("hold_stable", longint'(stable), 1);
        a_if.out_ready = 1'b1;
        tick();
        a_if.start = 1'b0;
        check("start_in_done_ignored", longint'(a_if.busy), 0);
        tick();
        check("idle_after_done_in_ready", longint'(a_if.in_ready), 0);
    endtask

    task automatic run_block(input logic [NM-1:0] mask, input int kind, input int gap,
                             input bit noise, input bit hold, input bit lat);
        start_block(mask);
        a_if.out_ready = !hold;
        drive_beats(kind, gap, noise, BEATS);
        q17.push_back(model(tot, mask, 64'd131071));
        q16.push_back(model(tot, mask, 64'd65535));
        if (lat) begin
            a_if.in_valid = 1'b1;
            a_if.res_data = rand_data();
            check_latency();
            a_if.in_valid = 1'b0;
        end else if (hold) begin
            hold_check();
        end
        wait_idle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, longint'(a_if.in_ready), 0);
        check({tag, "_busy"}, longint'(a_if.busy), 0);
        check({tag, "_out_valid"}, longint'(a_if.out_valid), 0);
        check({tag, "_sads_nonzero"}, longint'(a_if.sads != '0), 0);
        check({tag, "_best_mode"}, longint'(a_if.best_mode), 0);
        check({tag, "_best_sad17"}, longint'(a_if.best_sad), 131071);
        check({tag, "_best_sad16"}, longint'(b_if.best_sad), 65535);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.start     = 1'b0;
        a_if.mode_mask = '0;
        a_if.in_valid  = 1'b0;
        a_if.res_data  = '0;
        a_if.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("rst");

        // beats offered while idle must be ignored
        a_if.in_valid = 1'b1;
        a_if.res_data = rand_data();
        repeat (3) tick();
        a_if.in_valid = 1'b0;
        check("idle_ignores_in_valid", longint'(a_if.busy), 0);

        cur_vals = '{1, 1, 1, 1};
        run_block(4'b1111, 0, 0, 1'b0, 1'b0, 1'b1);
        cur_vals = '{-1, -2, 0, -4};
        run_block(4'b1111, 0, 0, 1'b0, 1'b0, 1'b1);
        cur_vals = '{-256, -256, -256, -256};
        run_block(4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
        cur_vals = '{1, -3, 0, 2};
        run_block(4'b1010, 0, 0, 1'b0, 1'b0, 1'b0);
        run_block(4'b0000, 1, 20, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++)
            run_block(NM'($urandom), 1, 30, 1'b1, (r == 2), 1'b0);

        // abort mid-block, then a clean block must see none of the aborted beats
        start_block(4'b1111);
        drive_beats(1, 0, 1'b0, 7);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("abort_idle");
        run_block(4'b1111, 1, 10, 1'b0, 1'b0, 1'b1);

        repeat (5) tick();
        check("sb17_left_over", q17.size(), 0);
        check("sb16_left_over", q16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
